// File: rtl/io_supply_seq.sv
// Core-side power sequencer for the IO ring: debounces the synchronized VDDIO/VDD
// good indicators, then releases pad isolation and output enables in order.
module io_supply_seq #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int SETTLE_CYCLES   = 16,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vddio_ok_a,
  input  logic       vdd_ok_a,
  input  logic       pd_req,
  input  logic       fault_clr,
  output logic       pad_iso,
  output logic       pad_oe_en,
  output logic       pwr_good,
  output logic       pd_ack,
  output logic       fault_sticky,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_WAIT   = 3'd1,
    S_SETTLE = 3'd2,
    S_UNISO  = 3'd3,
    S_ACTIVE = 3'd4,
    S_DOWN   = 3'd5,
    S_ISO    = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] vio_sync_q;
  logic [SYNC_STAGES-1:0] vio_sync_d;
  logic [SYNC_STAGES-1:0] vdd_sync_q;
  logic [SYNC_STAGES-1:0] vdd_sync_d;
  logic                   vio_s;
  logic                   vdd_s;
  logic                   ok_s;

  state_e                 state_q;
  state_e                 state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   fault_set;

  logic                   pad_iso_q;
  logic                   pad_iso_d;
  logic                   pad_oe_en_q;
  logic                   pad_oe_en_d;
  logic                   pwr_good_q;
  logic                   pwr_good_d;
  logic                   pd_ack_q;
  logic                   pd_ack_d;
  logic                   fault_sticky_q;
  logic                   fault_sticky_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Plain shift-register synchronizers; only the last stage is ever consumed.
  always_comb begin
    vio_sync_d = {vio_sync_q[SYNC_STAGES-2:0], vddio_ok_a};
    vdd_sync_d = {vdd_sync_q[SYNC_STAGES-2:0], vdd_ok_a};
    vio_s      = vio_sync_q[SYNC_STAGES-1];
    vdd_s      = vdd_sync_q[SYNC_STAGES-1];
    ok_s       = vio_s & vdd_s;
  end

  always_comb begin
    state_d   = state_q;
    fault_set = 1'b0;
    case (state_q)
      S_OFF: begin
        if (!pd_req) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ok_s && (cnt_q == DEB_LAST)) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (!ok_s) begin
          state_d   = S_ISO;
          fault_set = 1'b1;
        end else if (cnt_q == SET_LAST) begin
          state_d = S_UNISO;
        end
      end
      S_UNISO: begin
        if (!ok_s) begin
          state_d   = S_DOWN;
          fault_set = 1'b1;
        end else begin
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        // Supply loss is flagged as a fault even if pd_req arrives together with it.
        if (!ok_s) begin
          state_d   = S_DOWN;
          fault_set = 1'b1;
        end else if (pd_req) begin
          state_d = S_DOWN;
        end
      end
      S_DOWN:  state_d = S_ISO;
      S_ISO:   state_d = S_OFF;
      default: state_d = S_ISO;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (state_d == state_q) begin
      if (state_q == S_WAIT) begin
        cnt_d = ok_s ? sat_inc(cnt_q) : '0;
      end else if (state_q == S_SETTLE) begin
        cnt_d = sat_inc(cnt_q);
      end
    end
  end

  // Outputs decode the next state so they switch on the same edge as state.
  always_comb begin
    pad_iso_d      = !((state_d == S_UNISO) || (state_d == S_ACTIVE) || (state_d == S_DOWN));
    pad_oe_en_d    = (state_d == S_ACTIVE);
    pwr_good_d     = (state_d == S_ACTIVE);
    pd_ack_d       = (state_d == S_OFF) && pd_req;
    fault_sticky_d = fault_set | (fault_sticky_q & ~fault_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vio_sync_q     <= '0;
      vdd_sync_q     <= '0;
      state_q        <= S_OFF;
      cnt_q          <= '0;
      pad_iso_q      <= 1'b1;
      pad_oe_en_q    <= 1'b0;
      pwr_good_q     <= 1'b0;
      pd_ack_q       <= 1'b0;
      fault_sticky_q <= 1'b0;
    end else begin
      vio_sync_q     <= vio_sync_d;
      vdd_sync_q     <= vdd_sync_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pad_iso_q      <= pad_iso_d;
      pad_oe_en_q    <= pad_oe_en_d;
      pwr_good_q     <= pwr_good_d;
      pd_ack_q       <= pd_ack_d;
      fault_sticky_q <= fault_sticky_d;
    end
  end

  assign pad_iso      = pad_iso_q;
  assign pad_oe_en    = pad_oe_en_q;
  assign pwr_good     = pwr_good_q;
  assign pd_ack       = pd_ack_q;
  assign fault_sticky = fault_sticky_q;
  assign state        = state_q;

endmodule

// File: tb/tb_io_supply_seq.sv
// Bench for io_supply_seq: directed sequencing scenarios plus a randomized run,
// all compared against a cycle-level reference model of the sequencing rules.
module tb_io_supply_seq;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 8;
  localparam int SETTLE_CYCLES   = 16;
  localparam int CNT_W           = 8;
  localparam int CNT_MAX         = (1 << CNT_W) - 1;

  localparam int ST_OFF = 0, ST_WAIT = 1, ST_SETTLE = 2, ST_UNISO = 3;
  localparam int ST_ACTIVE = 4, ST_DOWN = 5, ST_ISO = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vddio_ok_a = 1'b1;
  logic       vdd_ok_a = 1'b1;
  logic       pd_req = 1'b0;
  logic       fault_clr = 1'b0;
  logic       pad_iso;
  logic       pad_oe_en;
  logic       pwr_good;
  logic       pd_ack;
  logic       fault_sticky;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  bit [1:0] m_hist[$];
  int       m_state;
  int       m_cnt;
  bit       m_fault;
  bit       e_iso, e_oe, e_pg, e_ack;
  logic     prev_iso, prev_oe;

  io_supply_seq #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SETTLE_CYCLES  (SETTLE_CYCLES),
    .CNT_W          (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vddio_ok_a  (vddio_ok_a),
    .vdd_ok_a    (vdd_ok_a),
    .pd_req      (pd_req),
    .fault_clr   (fault_clr),
    .pad_iso     (pad_iso),
    .pad_oe_en   (pad_oe_en),
    .pwr_good    (pwr_good),
    .pd_ack      (pd_ack),
    .fault_sticky(fault_sticky),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    m_hist = {};
    repeat (SYNC_STAGES) m_hist.push_back(2'b00);
    m_state = ST_OFF;
    m_cnt   = 0;
    m_fault = 1'b0;
    e_iso   = 1'b1;
    e_oe    = 1'b0;
    e_pg    = 1'b0;
    e_ack   = 1'b0;
  endtask

  // The synchronizer is modelled as a pure SYNC_STAGES-sample delay line.
  task automatic model_step();
    bit ok;
    bit fset;
    int nxt;
    ok   = m_hist[0][1] && m_hist[0][0];
    nxt  = m_state;
    fset = 1'b0;
    if (m_state == ST_OFF) begin
      if (!pd_req) nxt = ST_WAIT;
    end else if (m_state == ST_WAIT) begin
      if (ok && m_cnt == DEBOUNCE_CYCLES - 1) nxt = ST_SETTLE;
    end else if (m_state == ST_SETTLE) begin
      if (!ok) begin nxt = ST_ISO; fset = 1'b1; end
      else if (m_cnt == SETTLE_CYCLES - 1) nxt = ST_UNISO;
    end else if (m_state == ST_UNISO) begin
      if (!ok) begin nxt = ST_DOWN; fset = 1'b1; end
      else nxt = ST_ACTIVE;
    end else if (m_state == ST_ACTIVE) begin
      if (!ok) begin nxt = ST_DOWN; fset = 1'b1; end
      else if (pd_req) nxt = ST_DOWN;
    end else if (m_state == ST_DOWN) begin
      nxt = ST_ISO;
    end else begin
      nxt = ST_OFF;
    end
    if (nxt != m_state) m_cnt = 0;
    else if (m_state == ST_WAIT) m_cnt = ok ? ((m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt) : 0;
    else if (m_state == ST_SETTLE) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
    m_fault = fset || (m_fault && !fault_clr);
    m_state = nxt;
    e_iso   = !(nxt inside {ST_UNISO, ST_ACTIVE, ST_DOWN});
    e_oe    = (nxt == ST_ACTIVE);
    e_pg    = (nxt == ST_ACTIVE);
    e_ack   = (nxt == ST_OFF) && pd_req;
    void'(m_hist.pop_front());
    m_hist.push_back({vddio_ok_a, vdd_ok_a});
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    model_step();
    #1;
    chk("state", state, m_state);
    chk("pad_iso", pad_iso, e_iso);
    chk("pad_oe_en", pad_oe_en, e_oe);
    chk("pwr_good", pwr_good, e_pg);
    chk("pd_ack", pd_ack, e_ack);
    chk("fault_sticky", fault_sticky, m_fault);
    chk("inv_oe_needs_uniso", pad_oe_en & pad_iso, 0);
    chk("inv_oe_needs_pg", pad_oe_en & ~pwr_good, 0);
    chk("inv_oe_rise_iso_fall", (!prev_oe && pad_oe_en && prev_iso && !pad_iso), 0);
    chk("inv_state7", (state == 3'd7), 0);
    prev_iso = pad_iso;
    prev_oe  = pad_oe_en;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, state, ST_OFF);
    chk({tag, "_iso"}, pad_iso, 1);
    chk({tag, "_oe"}, pad_oe_en, 0);
    chk({tag, "_pg"}, pwr_good, 0);
    chk({tag, "_ack"}, pd_ack, 0);
    chk({tag, "_fault"}, fault_sticky, 0);
  endtask

  // Called away from a clock edge: the 1 ns check sees the async reset alone.
  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #1;
    check_reset_vals(tag);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    edge_n   = 0;
    prev_iso = 1'b1;
    prev_oe  = 1'b0;
  endtask

  task automatic wait_state(input int target, input int max_edges, input string tag,
                            output int at_edge);
    at_edge = -1;
    for (int i = 0; i < max_edges; i++) begin
      tick();
      if (state == target[2:0]) begin
        at_edge = edge_n;
        break;
      end
    end
    chk({tag, "_reached"}, state, target);
  endtask

  initial begin
    int iso_fall, oe_rise, pg_rise, at, base;
    #1;
    apply_reset("rst_init");

    // Power-up with both supplies already good.
    iso_fall = -1; oe_rise = -1; pg_rise = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (iso_fall < 0 && !pad_iso) iso_fall = edge_n;
      if (oe_rise < 0 && pad_oe_en) oe_rise = edge_n;
      if (pg_rise < 0 && pwr_good) pg_rise = edge_n;
    end
    chk("up_iso_fall_edge", iso_fall, 26);
    chk("up_oe_rise_edge", oe_rise, 27);
    chk("up_pg_rise_edge", pg_rise, 27);
    chk("up_active", state, ST_ACTIVE);

    // Supply loss in ACTIVE.
    vddio_ok_a = 1'b0;
    tick(); tick(); tick();
    chk("loss_oe_low", pad_oe_en, 0);
    chk("loss_state_down", state, ST_DOWN);
    tick();
    chk("loss_iso_high", pad_iso, 1);
    chk("loss_state_iso", state, ST_ISO);
    tick();
    chk("loss_state_off", state, ST_OFF);
    tick();
    chk("loss_state_wait", state, ST_WAIT);
    chk("loss_fault_set", fault_sticky, 1);
    repeat (3) tick();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("loss_fault_cleared", fault_sticky, 0);
    vddio_ok_a = 1'b1;

    // Debounce glitch in WAIT after five counted cycles.
    apply_reset("rst_glitch");
    repeat (5) tick();
    vdd_ok_a = 1'b0;
    repeat (3) tick();
    vdd_ok_a = 1'b1;
    wait_state(ST_SETTLE, 40, "glitch_settle", at);
    chk("glitch_settle_edge", at, 18);

    // Software power-down from ACTIVE, then release.
    wait_state(ST_ACTIVE, 40, "pd_reach_active", at);
    pd_req = 1'b1;
    tick();
    chk("pd_oe_low", pad_oe_en, 0);
    chk("pd_iso_still_low", pad_iso, 0);
    tick();
    chk("pd_iso_high", pad_iso, 1);
    tick();
    chk("pd_off", state, ST_OFF);
    chk("pd_ack_high", pd_ack, 1);
    chk("pd_no_fault", fault_sticky, 0);
    repeat (4) tick();
    chk("pd_hold_off", state, ST_OFF);
    chk("pd_hold_ack", pd_ack, 1);
    pd_req = 1'b0;
    base = edge_n;
    tick();
    chk("pd_release_wait", state, ST_WAIT);
    chk("pd_release_ack", pd_ack, 0);
    wait_state(ST_ACTIVE, 40, "pd_reup", at);
    chk("pd_reup_edges", at - base, 26);

    // Asynchronous reset mid-SETTLE and mid-ACTIVE.
    apply_reset("rst_pre_settle");
    repeat (15) tick();
    chk("settle_before_rst", state, ST_SETTLE);
    #2;
    apply_reset("rst_async_settle");
    wait_state(ST_ACTIVE, 40, "active_before_rst", at);
    chk("oe_before_rst", pad_oe_en, 1);
    #2;
    apply_reset("rst_async_active");

    // Randomized supplies, power-down requests and fault clears.
    for (int i = 0; i < 3000; i++) begin
      if (vddio_ok_a) begin
        if ($urandom_range(59) == 0) vddio_ok_a = 1'b0;
      end else if ($urandom_range(4) == 0) vddio_ok_a = 1'b1;
      if (vdd_ok_a) begin
        if ($urandom_range(59) == 0) vdd_ok_a = 1'b0;
      end else if ($urandom_range(4) == 0) vdd_ok_a = 1'b1;
      if ($urandom_range(99) == 0) pd_req = ~pd_req;
      fault_clr = ($urandom_range(24) == 0);
      tick();
    end
    fault_clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
